// File: rtl/syn_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | syn_seq_if : control/config/datapath-select bundle for syn_seq        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface syn_seq_if #(
  parameter int ADDR_DMEM  = 8,
  parameter int ADDR_CMEM  = 6,
  parameter int CONF_WIDTH = 24,
  parameter int ITER_WIDTH = 8
);
  logic                  cfg_we;
  logic [ADDR_CMEM-1:0]  cfg_waddr;
  logic [CONF_WIDTH-1:0] cfg_wdata;
  logic                  start;
  logic [ADDR_CMEM-1:0]  cfg_base;
  logic [ITER_WIDTH-1:0] n_iter;
  logic [ADDR_DMEM-1:0]  r_base;
  logic [ADDR_DMEM-1:0]  w_base;
  logic                  busy;
  logic                  done;
  logic [1:0]            sel_m_mux1;
  logic [1:0]            sel_m_mux2;
  logic                  sel_a_mux1;
  logic [1:0]            sel_a_mux2;
  logic                  sel_a1;
  logic                  sel_a2;
  logic [1:0]            sel_v_line;
  logic [1:0]            sel_h_line;
  logic [1:0]            sel_ram_i;
  logic                  we_ram;
  logic [ADDR_DMEM-1:0]  r_addr;
  logic [ADDR_DMEM-1:0]  w_addr;

  modport master (
    output cfg_we, cfg_waddr, cfg_wdata, start, cfg_base, n_iter, r_base, w_base,
    input  busy, done, sel_m_mux1, sel_m_mux2, sel_a_mux1, sel_a_mux2, sel_a1,
           sel_a2, sel_v_line, sel_h_line, sel_ram_i, we_ram, r_addr, w_addr
  );

  modport slave (
    input  cfg_we, cfg_waddr, cfg_wdata, start, cfg_base, n_iter, r_base, w_base,
    output busy, done, sel_m_mux1, sel_m_mux2, sel_a_mux1, sel_a_mux2, sel_a1,
           sel_a2, sel_v_line, sel_h_line, sel_ram_i, we_ram, r_addr, w_addr
  );
endinterface
`default_nettype wire

// File: rtl/syn_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | syn_seq : CMEM-driven micro-sequencer for one synapse datapath tile   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module syn_seq #(
  parameter int ADDR_DMEM  = 8,
  parameter int ADDR_CMEM  = 6,
  parameter int CONF_WIDTH = 24,
  parameter int ITER_WIDTH = 8,
  parameter int WR_LAT     = 2
) (
  input  logic      clk,
  input  logic      rst,
  syn_seq_if.slave  bus
);

  localparam int DW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam int PW = 3 + ADDR_DMEM;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state, state_nx;
  logic [CONF_WIDTH-1:0] cmem [(1 << ADDR_CMEM)];
  logic [CONF_WIDTH-1:0] word;
  logic [ADDR_CMEM-1:0]  pc;
  logic [ADDR_CMEM-1:0]  base;
  logic [ADDR_DMEM-1:0]  r_cnt;
  logic [ADDR_DMEM-1:0]  w_cnt;
  logic [ITER_WIDTH-1:0] iter;
  logic [DW-1:0]         drain_cnt;
  logic [PW-1:0]         wpipe [WR_LAT];
  logic                  exec_op;
  logic                  unused_rsvd;

  assign exec_op     = (state == EXEC);
  assign unused_rsvd = ^word[CONF_WIDTH-1:19];

  always_ff @(posedge clk) begin
    if (bus.cfg_we && (state == IDLE)) begin
      cmem[bus.cfg_waddr] <= bus.cfg_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.busy       = (state != IDLE);
    bus.done       = (state == DONE);
    bus.sel_m_mux1 = 2'b0;
    bus.sel_m_mux2 = 2'b0;
    bus.sel_a_mux1 = 1'b0;
    bus.sel_a_mux2 = 2'b0;
    bus.sel_a1     = 1'b0;
    bus.sel_a2     = 1'b0;
    bus.sel_v_line = 2'b0;
    bus.sel_h_line = 2'b0;
    bus.r_addr     = '0;
    case (state)
      IDLE: begin
        if (bus.start) state_nx = (bus.n_iter == '0) ? DONE : FETCH;
      end
      FETCH: state_nx = EXEC;
      EXEC: begin
        bus.sel_m_mux1 = word[1:0];
        bus.sel_m_mux2 = word[3:2];
        bus.sel_a_mux1 = word[4];
        bus.sel_a_mux2 = word[6:5];
        bus.sel_a1     = word[7];
        bus.sel_a2     = word[8];
        bus.sel_v_line = word[10:9];
        bus.sel_h_line = word[12:11];
        bus.r_addr     = r_cnt;
        if (word[18]) state_nx = (iter > ITER_WIDTH'(1)) ? FETCH : DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DW'(WR_LAT - 1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word      <= '0;
      pc        <= '0;
      base      <= '0;
      r_cnt     <= '0;
      w_cnt     <= '0;
      iter      <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            pc    <= bus.cfg_base;
            base  <= bus.cfg_base;
            r_cnt <= bus.r_base;
            w_cnt <= bus.w_base;
            iter  <= bus.n_iter;
          end
        end
        FETCH: begin
          word <= cmem[pc];
          pc   <= pc + 1'b1;
        end
        EXEC: begin
          drain_cnt <= '0;
          if (word[16]) r_cnt <= r_cnt + 1'b1;
          if (word[17]) w_cnt <= w_cnt + 1'b1;
          // The LAST word restarts the body via FETCH, costing one bubble per loop.
          if (word[18]) begin
            if (iter > ITER_WIDTH'(1)) begin
              iter <= iter - 1'b1;
              pc   <= base;
            end
          end else begin
            word <= cmem[pc];
            pc   <= pc + 1'b1;
          end
        end
        DRAIN:   drain_cnt <= drain_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Write side trails issue by WR_LAT cycles to line up with the arithmetic pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WR_LAT; i++) wpipe[i] <= '0;
    end else begin
      wpipe[0] <= exec_op ? {word[15], word[14:13], w_cnt} : '0;
      for (int i = 1; i < WR_LAT; i++) wpipe[i] <= wpipe[i-1];
    end
  end

  assign bus.we_ram    = wpipe[WR_LAT-1][PW-1];
  assign bus.sel_ram_i = wpipe[WR_LAT-1][PW-2:PW-3];
  assign bus.w_addr    = wpipe[WR_LAT-1][ADDR_DMEM-1:0];

endmodule
`default_nettype wire

// File: tb/tb_syn_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_syn_seq : directed self-checking bench for syn_seq                 |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_syn_seq;

  localparam logic [23:0] C_W1   = 24'h07E005;  // m1=1 m2=1 ramsel=3 we r_inc w_inc LAST
  localparam logic [23:0] C_W10  = 24'h000155;
  localparam logic [23:0] C_W11  = 24'h000AAA;
  localparam logic [23:0] C_W12  = 24'h001234;
  localparam logic [23:0] C_W13  = 24'h040F0F;
  localparam logic [23:0] C_W20  = 24'h050002;  // m1=2 r_inc LAST
  localparam logic [23:0] C_JUNK = 24'h041FFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  syn_seq_if bus ();

  syn_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sels();
    return 32'({bus.sel_h_line, bus.sel_v_line, bus.sel_a2, bus.sel_a1,
                bus.sel_a_mux2, bus.sel_a_mux1, bus.sel_m_mux2, bus.sel_m_mux1});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ra < 0 means r_addr is not checked; w_addr/sel_ram_i checked only with we expected
  task automatic cyc(input string tag, input logic b, input logic d, input logic [31:0] s,
                     input int ra, input logic we, input logic [1:0] rs, input logic [7:0] wa);
    check({tag, " busy"}, 32'(bus.busy), 32'(b));
    check({tag, " done"}, 32'(bus.done), 32'(d));
    check({tag, " sels"}, sels(), s);
    check({tag, " we_ram"}, 32'(bus.we_ram), 32'(we));
    if (ra >= 0) check({tag, " r_addr"}, 32'(bus.r_addr), 32'(ra));
    if (we) begin
      check({tag, " sel_ram_i"}, 32'(bus.sel_ram_i), 32'(rs));
      check({tag, " w_addr"}, 32'(bus.w_addr), 32'(wa));
    end
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [23:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_waddr = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic start_run(input logic [5:0] cb, input logic [7:0] n, input logic [7:0] rb,
                           input logic [7:0] wb);
    bus.start    = 1'b1;
    bus.cfg_base = cb;
    bus.n_iter   = n;
    bus.r_base   = rb;
    bus.w_base   = wb;
    tick();
    bus.start    = 1'b0;
  endtask

  // Three passes of the single-word body at CMEM[0]; optionally pokes start/cfg_we mid-run.
  task automatic run_w1(input string p, input bit meddle);
    start_run(6'd0, 8'd3, 8'h10, 8'h20);
    cyc({p, " fetch"}, 1, 0, 0, -1, 0, 0, 0); tick();
    cyc({p, " exec1"}, 1, 0, 'h005, 'h10, 0, 0, 0);
    if (meddle) begin
      bus.start     = 1'b1;
      bus.cfg_base  = 6'd20;
      bus.n_iter    = 8'd1;
      bus.r_base    = 8'h99;
      bus.cfg_we    = 1'b1;
      bus.cfg_waddr = 6'd0;
      bus.cfg_wdata = C_JUNK;
    end
    tick();
    cyc({p, " bub1"},   1, 0, 0, -1, 0, 0, 0); tick();
    cyc({p, " exec2"},  1, 0, 'h005, 'h11, 1, 3, 8'h20); tick();
    cyc({p, " bub2"},   1, 0, 0, -1, 0, 0, 0); tick();
    cyc({p, " exec3"},  1, 0, 'h005, 'h12, 1, 3, 8'h21); tick();
    cyc({p, " drain1"}, 1, 0, 0, -1, 0, 0, 0); tick();
    cyc({p, " drain2"}, 1, 0, 0, -1, 1, 3, 8'h22); tick();
    cyc({p, " done"},   1, 1, 0, -1, 0, 0, 0);
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    tick();
    cyc({p, " idle"},   0, 0, 0, -1, 0, 0, 0);
  endtask

  // Single pass of CMEM[0]: shows whether it still holds C_W1.
  task automatic readback(input string p);
    start_run(6'd0, 8'd1, 8'h40, 8'h50);
    cyc({p, " fetch"},  1, 0, 0, -1, 0, 0, 0); tick();
    cyc({p, " exec"},   1, 0, 'h005, 'h40, 0, 0, 0); tick();
    cyc({p, " drain1"}, 1, 0, 0, -1, 0, 0, 0); tick();
    cyc({p, " drain2"}, 1, 0, 0, -1, 1, 3, 8'h50); tick();
    cyc({p, " done"},   1, 1, 0, -1, 0, 0, 0); tick();
    cyc({p, " idle"},   0, 0, 0, -1, 0, 0, 0);
  endtask

  initial begin
    int exp2 [13];
    int n_exec;
    bus.cfg_we    = 1'b0;
    bus.cfg_waddr = '0;
    bus.cfg_wdata = '0;
    bus.start     = 1'b0;
    bus.cfg_base  = '0;
    bus.n_iter    = '0;
    bus.r_base    = '0;
    bus.w_base    = '0;

    tick();
    tick();
    cyc("reset", 0, 0, 0, 0, 0, 0, 0);
    check("reset w_addr", 32'(bus.w_addr), 32'h0);
    rst = 1'b0;
    tick();

    cfg_write(6'd0,  C_W1);
    cfg_write(6'd10, C_W10);
    cfg_write(6'd11, C_W11);
    cfg_write(6'd12, C_W12);
    cfg_write(6'd13, C_W13);
    cfg_write(6'd20, C_W20);

    // basic three-iteration loop
    run_w1("t1", 1'b0);

    // four-word body, two iterations
    exp2 = '{0, 'h155, 'hAAA, 'h1234, 'hF0F, 0, 'h155, 'hAAA, 'h1234, 'hF0F, 0, 0, 0};
    n_exec = 0;
    start_run(6'd10, 8'd2, 8'h30, 8'h00);
    for (int i = 0; i < 13; i++) begin
      cyc($sformatf("t2 c%0d", i), 1, (i == 12), exp2[i], (exp2[i] != 0) ? 'h30 : -1, 0, 0, 0);
      if (sels() != 0) n_exec++;
      tick();
    end
    check("t2 busy end", 32'(bus.busy), 32'h0);
    check("t2 exec count", 32'(n_exec), 32'd8);

    // zero iterations
    start_run(6'd0, 8'd0, 8'h00, 8'h00);
    cyc("t3 done", 1, 1, 0, -1, 0, 0, 0); tick();
    cyc("t3 idle", 0, 0, 0, -1, 0, 0, 0); tick();
    cyc("t3 after", 0, 0, 0, -1, 0, 0, 0);

    // read address wrap
    start_run(6'd20, 8'd2, 8'hFF, 8'h00);
    cyc("t4 fetch1", 1, 0, 0, -1, 0, 0, 0); tick();
    cyc("t4 exec1",  1, 0, 'h002, 'hFF, 0, 0, 0); tick();
    cyc("t4 fetch2", 1, 0, 0, -1, 0, 0, 0); tick();
    cyc("t4 exec2",  1, 0, 'h002, 'h00, 0, 0, 0); tick();
    cyc("t4 drain1", 1, 0, 0, -1, 0, 0, 0); tick();
    cyc("t4 drain2", 1, 0, 0, -1, 0, 0, 0); tick();
    cyc("t4 done",   1, 1, 0, -1, 0, 0, 0); tick();
    cyc("t4 idle",   0, 0, 0, -1, 0, 0, 0);

    // start/cfg_we while busy are ignored
    run_w1("t5", 1'b1);
    readback("t5 rb");

    // asynchronous reset with a write pending
    start_run(6'd0, 8'd3, 8'h10, 8'h20);
    tick();
    tick();
    tick();
    cyc("t6 exec2", 1, 0, 'h005, 'h11, 1, 3, 8'h20);
    #2;
    rst = 1'b1;
    #1;
    cyc("t6 rst", 0, 0, 0, 0, 0, 0, 0);
    check("t6 rst w_addr", 32'(bus.w_addr), 32'h0);
    tick();
    cyc("t6 rst hold", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    cyc("t6 idle1", 0, 0, 0, -1, 0, 0, 0); tick();
    cyc("t6 idle2", 0, 0, 0, -1, 0, 0, 0);
    readback("t6 rb");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/syn_seq.md
Name: syn_seq

Overview:
- Micro-sequencer that drives one synapse datapath tile.
- Holds a local configuration memory (CMEM) of control words. On start, it steps through the words from cfg_base until a word with the LAST bit set, and repeats the body n_iter times.
- Each cycle it drives the datapath mux selects, the DMEM read/write addresses and the DMEM write enable.
- DMEM writes are delayed by WrLat cycles to match the multiplier/adder pipeline.

Parameters:
- AddrDMEM, 8, DMEM address width.
- AddrCMEM, 6, CMEM address width (64 words).
- ConfWidth, 24, CMEM word width.
- IterWidth, 8, width of the loop count.
- WrLat, 2, cycles from op issue to the DMEM write (at least 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cfg_we  in  1  CMEM write strobe
- cfg_waddr  in  AddrCMEM  CMEM write address
- cfg_wdata  in  ConfWidth  CMEM write data
- start  in  1  start pulse; sampled only in IDLE
- cfg_base  in  AddrCMEM  first word of the loop body; latched on start
- n_iter  in  IterWidth  loop count; latched on start
- r_base  in  AddrDMEM  initial read address; latched on start
- w_base  in  AddrDMEM  initial write address; latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at completion
- sel_m_mux1  out  2  multiplier operand-1 select
- sel_m_mux2  out  2  multiplier operand-2 select
- sel_a_mux1  out  1  adder operand-1 select
- sel_a_mux2  out  2  adder operand-2 select
- sel_a1  out  1  adder fan-out 1 enable
- sel_a2  out  1  adder fan-out 2 enable
- sel_v_line  out  2  vertical line select
- sel_h_line  out  2  horizontal line select
- sel_ram_i  out  2  DMEM write-data select; delayed by WrLat
- we_ram  out  1  DMEM write enable; delayed by WrLat
- r_addr  out  AddrDMEM  DMEM read address
- w_addr  out  AddrDMEM  DMEM write address; delayed by WrLat

Behaviour:
- Control word fields:
  - [1:0] m1, [3:2] m2, [4] a1mux, [6:5] a2mux, [7] a1, [8] a2
  - [10:9] vline, [12:11] hline, [14:13] ramsel, [15] we
  - [16] r_inc, [17] w_inc, [18] LAST, [23:19] reserved (ignored)
- Reset (asynchronous): state goes to IDLE; all outputs, counters and the delay pipeline go to 0. CMEM contents are not reset.
- CMEM writes:
  - Accepted only in IDLE; cfg_we while busy is ignored.
  - CMEM read is synchronous, 1-cycle latency.
- FSM states: IDLE, FETCH, EXEC, DRAIN, DONE.
- IDLE:
  - start=1 latches pc=cfg_base, r_cnt=r_base, w_cnt=w_base, iter=n_iter.
  - If n_iter=0, go to DONE with no ops executed; otherwise go to FETCH.
- FETCH:
  - Issues a read of CMEM[pc], pc<=pc+1; goes to EXEC.
  - All select/we outputs are 0 (bubble).
- EXEC, one op per cycle:
  - The issued word drives the non-delayed selects combinationally from the word register. r_addr=r_cnt.
  - Next word is prefetched, pc<=pc+1.
  - If r_inc: r_cnt+1. If w_inc: w_cnt+1 after issue.
- LAST word in EXEC:
  - If iter>1: iter-1, pc<=cfg_base, go to FETCH (one bubble per loop).
  - Else: go to DRAIN.
- pc wraps modulo 2^AddrCMEM. r_cnt and w_cnt wrap modulo 2^AddrDMEM.
- Write pipeline:
  - Each issued op pushes {we, ramsel, w_cnt-at-issue} into a WrLat-deep shift register. Bubbles push zeros.
  - we_ram, sel_ram_i and w_addr are the register's output.
- DRAIN: waits exactly WrLat cycles (selects are 0), then goes to DONE.
- DONE: done=1 for one cycle, busy still 1; next state is IDLE.
- start is ignored outside IDLE.
- Reset mid-run aborts immediately and drops pending writes; no done pulse.

Test Plan:
- Reset, then load CMEM[0]={m1=1,m2=1,we=1,ramsel=3,r_inc,w_inc,LAST}; start with cfg_base=0, n_iter=3, r_base=0x10, w_base=0x20.
  -> 3 EXEC cycles with r_addr 0x10, 0x11, 0x12.
  -> we_ram pulses WrLat=2 cycles after each, with w_addr 0x20, 0x21, 0x22.
  -> done 1 cycle after DRAIN; busy falls the following cycle.
- 4-word body at cfg_base=10, n_iter=2.
  -> op sequence 10,11,12,13,bubble,10,11,12,13.
  -> exactly 8 EXEC cycles, selects 0 in the bubble.
- n_iter=0 -> busy=1 for 1 cycle (DONE) with done=1; no we_ram ever.
- r_base=0xFF with r_inc, n_iter=2, 1-word body -> r_addr 0xFF then 0x00 (wrap).
- start and cfg_we asserted mid-run -> no restart, CMEM unchanged (read back after run).
- Assert rst during EXEC with a write pending -> all outputs 0 immediately, no we_ram, state IDLE, CMEM preserved.
